// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between eight clients and the shared-resource arbiter.
// master: client side (drives requests); slave: arbiter side (drives grants).
interface rr_arbiter8_if #(
  parameter int N   = 8,
  parameter int IDW = 3
);
  logic [N-1:0]   req;
  logic           done;
  logic           mode;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           timeout;

  modport master (
    output req, done, mode,
    input  gnt, gnt_id, busy, timeout
  );

  modport slave (
    input  req, done, mode,
    output gnt, gnt_id, busy, timeout
  );
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-requester arbiter, fixed-priority or round-robin selection.
// A grant is held until done, request withdrawal, or the hold limit expires,
// and every release is followed by exactly one idle (gnt=0) bubble cycle.
// All outputs come straight from registers.
module rr_arbiter8 #(
  parameter int N       = 8,
  parameter int IDW     = 3,
  parameter int MAXHOLD = 15
) (
  input  logic        clk,
  input  logic        rst,
  rr_arbiter8_if.slave sb
);

  // Hold counter just wide enough to reach MAXHOLD; at least one bit.
  localparam int CW = (MAXHOLD < 1) ? 1 : $clog2(MAXHOLD + 1);
  localparam logic [CW-1:0] HOLD_LAST = (MAXHOLD == 0) ? '0 : CW'(MAXHOLD - 1);
  localparam logic [N-1:0]  ONE_HOT0  = N'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_reg, state_next;
  logic [N-1:0]   gnt_reg, gnt_next;
  logic [IDW-1:0] gnt_id_reg, gnt_id_next;
  logic [IDW-1:0] ptr_reg, ptr_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           busy_reg, busy_next;
  logic           timeout_reg, timeout_next;

  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] scan_idx;
  logic           rel_user;
  logic           rel_hold;

  // State and output registers; reset drops any grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      gnt_reg     <= '0;
      gnt_id_reg  <= '0;
      ptr_reg     <= '0;
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      gnt_id_reg  <= gnt_id_next;
      ptr_reg     <= ptr_next;
      cnt_reg     <= cnt_next;
      busy_reg    <= busy_next;
      timeout_reg <= timeout_next;
    end
  end

  // Winner search plus next-state logic; the scan index wraps via IDW-bit math,
  // and starts at 0 in fixed mode or at the rotation pointer in round-robin.
  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    gnt_id_next  = gnt_id_reg;
    ptr_next     = ptr_reg;
    cnt_next     = cnt_reg;
    busy_next    = busy_reg;
    timeout_next = 1'b0;
    win_found    = 1'b0;
    win_idx      = '0;
    scan_idx     = '0;
    rel_user     = 1'b0;
    rel_hold     = 1'b0;

    for (int i = 0; i < N; i++) begin
      scan_idx = sb.mode ? (ptr_reg + IDW'(i)) : IDW'(i);
      if (!win_found && sb.req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end

    case (state_reg)
      IDLE: begin
        gnt_next    = '0;
        gnt_id_next = '0;
        busy_next   = 1'b0;
        if (win_found) begin
          state_next  = GRANT;
          gnt_next    = ONE_HOT0 << win_idx;
          gnt_id_next = win_idx;
          busy_next   = 1'b1;
          cnt_next    = '0;
          ptr_next    = win_idx + IDW'(1);
        end
      end
      GRANT: begin
        rel_user = sb.done || !sb.req[gnt_id_reg];
        rel_hold = (MAXHOLD != 0) && (cnt_reg == HOLD_LAST);
        if (rel_user || rel_hold) begin
          state_next   = IDLE;
          gnt_next     = '0;
          gnt_id_next  = '0;
          busy_next    = 1'b0;
          timeout_next = !rel_user;
        end else if (cnt_reg != '1) begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next  = IDLE;
        gnt_next    = '0;
        gnt_id_next = '0;
        busy_next   = 1'b0;
      end
    endcase
  end

  assign sb.gnt     = gnt_reg;
  assign sb.gnt_id  = gnt_id_reg;
  assign sb.busy    = busy_reg;
  assign sb.timeout = timeout_reg;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: inputs change and outputs are sampled on the
// falling edge, so the arbiter sees stable inputs at every rising edge.
module tb_rr_arbiter8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  rr_arbiter8_if #(.N(8), .IDW(3)) bus ();

  rr_arbiter8 #(.N(8), .IDW(3), .MAXHOLD(15)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  // Checks every output against an expected one-hot grant and timeout value.
  task automatic check_out(input string tag, input logic [7:0] exp_gnt, input logic exp_to);
    logic [2:0] exp_id;
    exp_id = 3'd0;
    for (int k = 0; k < 8; k++) if (exp_gnt[k]) exp_id = 3'(k);
    check({tag, ".gnt"},     32'(bus.gnt),     32'(exp_gnt));
    check({tag, ".gnt_id"},  32'(bus.gnt_id),  32'(exp_id));
    check({tag, ".busy"},    32'(bus.busy),    32'(|exp_gnt));
    check({tag, ".timeout"}, 32'(bus.timeout), 32'(exp_to));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    bus.req  = 8'h00;
    bus.done = 1'b0;
    bus.mode = 1'b0;

    // Reset state, then release with no requests.
    step(); step();
    check_out("reset", 8'h00, 1'b0);
    rst = 1'b0;
    step();
    check_out("idle_after_reset", 8'h00, 1'b0);

    // Async reset mid-cycle with all requests active drops gnt with no edge.
    bus.req = 8'hFF;
    step();
    check_out("pre_async_grant", 8'h01, 1'b0);
    #2 rst = 1'b1;
    #1 check_out("async_reset_ff", 8'h00, 1'b0);
    bus.req = 8'h00;
    step();
    rst = 1'b0;
    step();
    check_out("idle_after_release", 8'h00, 1'b0);

    // Fixed priority: lowest index wins, and it wins again after the bubble.
    bus.mode = 1'b0;
    bus.req  = 8'b1010_0100;
    step();
    check_out("fixed_first", 8'b0000_0100, 1'b0);
    bus.done = 1'b1;
    step();
    check_out("fixed_bubble", 8'h00, 1'b0);
    bus.done = 1'b0;
    step();
    check_out("fixed_again", 8'b0000_0100, 1'b0);
    bus.req = 8'h00;
    step();
    check_out("fixed_withdraw", 8'h00, 1'b0);

    // Pointer back to 0, then round-robin over all eight with done pulses.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.mode = 1'b1;
    bus.req  = 8'hFF;
    step();
    for (int i = 0; i < 9; i++) begin
      check_out($sformatf("rr_grant%0d", i), 8'(1 << (i % 8)), 1'b0);
      bus.done = 1'b1;
      step();
      check_out($sformatf("rr_bubble%0d", i), 8'h00, 1'b0);
      bus.done = 1'b0;
      if (i == 8) bus.req = 8'h00;
      step();
    end
    // Pointer now 1.

    // Skip and wrap: grant 5 (pointer 6), then 1, then 7.
    bus.req = 8'b0010_0000;
    step();
    check_out("rr_grant5", 8'b0010_0000, 1'b0);
    bus.req = 8'h00;
    step();
    check_out("withdraw5", 8'h00, 1'b0);
    bus.req = 8'b0000_0010;
    step();
    check_out("rr_wrap1", 8'b0000_0010, 1'b0);
    bus.req = 8'h00;
    step();
    bus.req = 8'b1000_0010;
    step();
    check_out("rr_skip7", 8'b1000_0000, 1'b0);
    bus.req = 8'h00;
    step();
    // Pointer now 0.

    // Hold limit: exactly 15 grant cycles, then a one-cycle timeout pulse.
    bus.req = 8'b0000_1000;
    step();
    for (int i = 0; i < 15; i++) begin
      check(
        $sformatf("hold_cyc%0d.gnt", i), 32'(bus.gnt), 32'h08);
      step();
    end
    check_out("timeout_pulse", 8'h00, 1'b1);
    bus.req = 8'b0001_1000;
    step();
    check_out("after_timeout_rr4", 8'b0001_0000, 1'b0);
    bus.req = 8'h00;
    step();
    check_out("withdraw4", 8'h00, 1'b0);

    // done in the final hold cycle wins over the hold limit: no timeout.
    bus.req = 8'b0010_0000;
    step();
    for (int i = 0; i < 14; i++) step();
    check_out("last_hold_cycle", 8'b0010_0000, 1'b0);
    bus.done = 1'b1;
    step();
    check_out("done_beats_timeout", 8'h00, 1'b0);
    bus.done = 1'b0;
    bus.req  = 8'h00;
    step();
    // Pointer now 6.

    // Grant interrupted by async reset; pointer returns to 0.
    bus.req = 8'hFF;
    step();
    check_out("rr_grant6", 8'b0100_0000, 1'b0);
    #2 rst = 1'b1;
    #1 check_out("async_reset_midgrant", 8'h00, 1'b0);
    step();
    rst = 1'b0;
    step();
    check_out("post_reset_rr0", 8'h01, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
